// File: rtl/sqrt_arb_pkg.sv
// sqrt_arb_pkg: shared state type, defaults and helpers
// for the round-robin sqrt core arbiter.
package sqrt_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic int rr_next(
    input int last,
    input int n
  );
    return (last >= n - 1) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/sqrt_rr_pick.sv
// sqrt_rr_pick: rotating-priority picker, searches upward
// from the slot after last_i and wraps modulo N_REQ.
import sqrt_arb_pkg::*;

module sqrt_rr_pick #(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     any_o
);

  localparam int GW = $clog2(N_REQ);

  logic [GW-1:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = GW'(rr_next(int'(last_i), N_REQ));
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_o && req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
      idx = (idx == GW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one sqrt core among N_REQ requesters,
// one transaction at a time, with a WAIT watchdog.
import sqrt_arb_pkg::*;

module sqrt_arbiter #(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                enb_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*DW-1:0] req_x_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [N_REQ-1:0]    rsp_valid_o,
  input  logic [N_REQ-1:0]    rsp_ready_i,
  output logic [DW-1:0]       rsp_r_o,
  output logic                rsp_err_o,
  output logic                core_valid_o,
  output logic [DW-1:0]       core_x_o,
  input  logic                core_busy_i,
  input  logic                core_ready_i,
  input  logic [DW-1:0]       core_r_i,
  output logic                busy_o
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] last_q, last_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] r_q, r_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [GW-1:0] pick;
  logic          any_req;
  logic          accept;
  logic          issue;
  logic          rsp_done;

  sqrt_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .grant_o(pick),
    .any_o  (any_req)
  );

  // Accept is gated by enb_i so no pulse escapes during reset.
  assign accept   = enb_i && (state_q == IDLE) && any_req;
  assign issue    = (state_q == ISSUE) && !core_busy_i;
  assign rsp_done = (state_q == RESP) && rsp_ready_i[g_q];

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    x_d     = x_q;
    r_d     = r_q;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          g_d     = pick;
          x_d     = req_x_i[pick*DW +: DW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_ready_i) begin
          r_d     = core_r_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          r_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_done) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge enb_i) begin
    if (!enb_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= GW'(N_REQ - 1);
      x_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      x_q     <= x_d;
      r_q     <= r_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign req_ready_o  = accept ? (N_REQ'(1) << pick) : '0;
  assign rsp_valid_o  = (state_q == RESP) ? (N_REQ'(1) << g_q) : '0;
  assign rsp_r_o      = (state_q == RESP) ? r_q : '0;
  assign rsp_err_o    = (state_q == RESP) && err_q;
  assign core_valid_o = issue;
  assign core_x_o     = x_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed vectors and corner-case sequences
// for sqrt_arbiter with a floor-sqrt core model.
module tb_sqrt_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  typedef struct {
    logic [N-1:0]   add;
    logic [N*W-1:0] xs;
    logic [N-1:0]   grant;
    logic [W-1:0]   x;
    logic [W-1:0]   r;
  } vec_t;

  logic           clk_i = 1'b0;
  logic           enb_i = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*W-1:0] req_x_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   rsp_valid_o;
  logic [N-1:0]   rsp_ready_i = '0;
  logic [W-1:0]   rsp_r_o;
  logic           rsp_err_o;
  logic           core_valid_o;
  logic [W-1:0]   core_x_o;
  logic           core_busy_i = 1'b0;
  logic           core_ready_i;
  logic [W-1:0]   core_r_i;
  logic           busy_o;

  int errors = 0;
  int checks = 0;

  logic       mute = 1'b0;
  logic       inject = 1'b0;
  logic [W-1:0] mx;
  int         cnt;

  vec_t vecs[10];

  sqrt_arbiter #(
    .N_REQ  (N),
    .DW     (W),
    .TIMEOUT(TO)
  ) dut (
    .clk_i       (clk_i),
    .enb_i       (enb_i),
    .req_valid_i (req_valid_i),
    .req_x_i     (req_x_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_r_o     (rsp_r_o),
    .rsp_err_o   (rsp_err_o),
    .core_valid_o(core_valid_o),
    .core_x_o    (core_x_o),
    .core_busy_i (core_busy_i),
    .core_ready_i(core_ready_i),
    .core_r_i    (core_r_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return W'(r);
  endfunction

  // Core model: answers three cycles after a start pulse.
  always @(posedge clk_i or negedge enb_i) begin
    if (!enb_i) begin
      cnt          <= 0;
      mx           <= '0;
      core_ready_i <= 1'b0;
      core_r_i     <= '0;
    end else begin
      core_ready_i <= inject || (cnt == 1 && !mute);
      core_r_i     <= inject ? 8'h55 : isqrt(mx);
      if (cnt != 0) cnt <= cnt - 1;
      else if (core_valid_o) begin
        cnt <= 3;
        mx  <= core_x_o;
      end
    end
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic finish_rsp(
    input logic [N-1:0] g,
    input logic [W-1:0] r,
    input logic         e
  );
    int n;
    n = 0;
    while (rsp_valid_o == '0 && n < 30) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("rsp_wait", 32'(n < 30), 1);
    chk("rsp_valid", rsp_valid_o, g);
    chk("rsp_r", rsp_r_o, r);
    chk("rsp_err", rsp_err_o, e);
    rsp_ready_i = rsp_valid_o;
    @(negedge clk_i);
    rsp_ready_i = '0;
    #1;
    chk("rsp_done", rsp_valid_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [N-1:0] acc;
    for (int k = 0; k < N; k++) begin
      if (v.add[k]) begin
        req_valid_i[k]     = 1'b1;
        req_x_i[k*W +: W] = v.xs[k*W +: W];
      end
    end
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("accept_wait", 32'(n < 20), 1);
    acc = req_ready_o;
    chk("grant", acc, v.grant);
    @(negedge clk_i);
    req_valid_i = req_valid_i & ~acc;
    #1;
    chk("accept_once", req_ready_o, 0);
    chk("core_valid", core_valid_o, 1);
    chk("core_x", core_x_o, v.x);
    @(negedge clk_i);
    #1;
    chk("core_valid_once", core_valid_o, 0);
    finish_rsp(v.grant, v.r, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b1111, 32'hFF640100, 4'b0001, 8'd0,   8'd0};
    vecs[1] = '{4'b0000, 32'h0,        4'b0010, 8'd1,   8'd1};
    vecs[2] = '{4'b0000, 32'h0,        4'b0100, 8'd100, 8'd10};
    vecs[3] = '{4'b0000, 32'h0,        4'b1000, 8'd255, 8'd15};
    vecs[4] = '{4'b0101, 32'h00400031, 4'b0001, 8'd49,  8'd7};
    vecs[5] = '{4'b0001, 32'h00000031, 4'b0100, 8'd64,  8'd8};
    vecs[6] = '{4'b0100, 32'h00400000, 4'b0001, 8'd49,  8'd7};
    vecs[7] = '{4'b0001, 32'h00000031, 4'b0100, 8'd64,  8'd8};
    vecs[8] = '{4'b0000, 32'h0,        4'b0001, 8'd49,  8'd7};
    vecs[9] = '{4'b0001, 32'h00000010, 4'b0001, 8'd16,  8'd4};

    // Reset state
    @(negedge clk_i);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_core_x", core_x_o, 0);
    chk("rst_rsp_r", rsp_r_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    req_valid_i = '1;
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    req_valid_i = '0;
    @(negedge clk_i);
    enb_i = 1'b1;

    for (int v = 0; v < 10; v++) run_vec(vecs[v]);

    // Core busy holds off the start pulse
    core_busy_i = 1'b1;
    req_valid_i[2] = 1'b1;
    req_x_i[23:16] = 8'd81;
    #1;
    chk("busy_grant", req_ready_o, 4'b0100);
    @(negedge clk_i);
    req_valid_i[2] = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("busy_hold", core_valid_o, 0);
      @(negedge clk_i);
      #1;
    end
    core_busy_i = 1'b0;
    #1;
    chk("busy_release", core_valid_o, 1);
    chk("busy_core_x", core_x_o, 8'd81);
    @(negedge clk_i);
    #1;
    chk("busy_pulse_once", core_valid_o, 0);
    finish_rsp(4'b0100, 8'd9, 1'b0);

    // Timeout with backpressure and late core ready
    mute = 1'b1;
    req_valid_i[1] = 1'b1;
    req_x_i[15:8]  = 8'd200;
    #1;
    chk("to_grant", req_ready_o, 4'b0010);
    @(negedge clk_i);
    req_valid_i[1] = 1'b0;
    #1;
    chk("to_core_valid", core_valid_o, 1);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk_i);
      #1;
      chk("to_wait", rsp_valid_o, 0);
    end
    @(negedge clk_i);
    #1;
    chk("to_rsp_valid", rsp_valid_o, 4'b0010);
    chk("to_rsp_err", rsp_err_o, 1);
    chk("to_rsp_r", rsp_r_o, 0);
    inject = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      inject = 1'b0;
      #1;
      chk("bp_valid", rsp_valid_o, 4'b0010);
      chk("bp_r", rsp_r_o, 0);
      chk("bp_err", rsp_err_o, 1);
    end
    rsp_ready_i = 4'b1101;
    @(negedge clk_i);
    #1;
    chk("bp_other_ready", rsp_valid_o, 4'b0010);
    rsp_ready_i = 4'b0010;
    @(negedge clk_i);
    rsp_ready_i = '0;
    #1;
    chk("to_done", rsp_valid_o, 0);
    chk("to_idle", busy_o, 0);
    inject = 1'b1;
    @(negedge clk_i);
    inject = 1'b0;
    @(negedge clk_i);
    #1;
    chk("late_ready_idle", busy_o, 0);
    chk("late_ready_rsp", rsp_valid_o, 0);
    mute = 1'b0;

    // Reset during WAIT
    req_valid_i[3] = 1'b1;
    req_x_i[31:24] = 8'd144;
    #1;
    chk("mr_grant", req_ready_o, 4'b1000);
    @(negedge clk_i);
    req_valid_i[3] = 1'b0;
    #1;
    chk("mr_core_valid", core_valid_o, 1);
    @(negedge clk_i);
    #1;
    chk("mr_wait_busy", busy_o, 1);
    enb_i = 1'b0;
    req_valid_i = 4'b1001;
    req_x_i[7:0] = 8'd144;
    #1;
    chk("mr_busy", busy_o, 0);
    chk("mr_rsp_valid", rsp_valid_o, 0);
    chk("mr_core_valid0", core_valid_o, 0);
    chk("mr_req_ready", req_ready_o, 0);
    chk("mr_core_x", core_x_o, 0);
    chk("mr_rsp_err", rsp_err_o, 0);
    @(negedge clk_i);
    enb_i = 1'b1;
    run_vec('{4'b0000, 32'h0, 4'b0001, 8'd144, 8'd12});
    run_vec('{4'b0000, 32'h0, 4'b1000, 8'd144, 8'd12});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
